// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared state encoding and slice geometry for the sequenced 64-bit CLA adder.
package cla_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W    = 16;
    localparam int NUM_SLICES = 4;
    localparam int IDX_W      = $clog2(NUM_SLICES);
endpackage

// File: rtl/cla_64bit_sequencer_cla16.sv
// cla16: 16-bit carry-lookahead adder built from four 4-bit groups and a lookahead carry unit.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    logic [15:0] g, p, c;
    logic [3:0] gg, gp;
    logic [4:0] gc;
    assign g = a & b;
    assign p = a ^ b;
    // Group carries are fully expanded so no group waits on its neighbour.
    assign gc[0] = c_in;
    assign gc[1] = gg[0] | gp[0] & c_in;
    assign gc[2] = gg[1] | gp[1] & gg[0] | gp[1] & gp[0] & c_in;
    assign gc[3] = gg[2] | gp[2] & gg[1] | gp[2] & gp[1] & gg[0] | gp[2] & gp[1] & gp[0] & c_in;
    assign gc[4] = gg[3] | gp[3] & gg[2] | gp[3] & gp[2] & gg[1] | gp[3] & gp[2] & gp[1] & gg[0]
                 | gp[3] & gp[2] & gp[1] & gp[0] & c_in;
    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign gp[k] = &p[4*k+3 -: 4];
        assign gg[k] = g[4*k+3] | p[4*k+3] & g[4*k+2] | p[4*k+3] & p[4*k+2] & g[4*k+1]
                     | p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k];
        assign c[4*k]   = gc[k];
        assign c[4*k+1] = g[4*k] | p[4*k] & gc[k];
        assign c[4*k+2] = g[4*k+1] | p[4*k+1] & g[4*k] | p[4*k+1] & p[4*k] & gc[k];
        assign c[4*k+3] = g[4*k+2] | p[4*k+2] & g[4*k+1] | p[4*k+2] & p[4*k+1] & g[4*k]
                        | p[4*k+2] & p[4*k+1] & p[4*k] & gc[k];
    end
    assign sum   = p ^ c;
    assign c_out = gc[4];
endmodule

// File: rtl/cla_64bit_sequencer.sv
// cla_64bit_sequencer: 64-bit add/sub computed one 16-bit slice per cycle through a single shared CLA.
module cla_64bit_sequencer
    import cla_seq_pkg::*;
#(
    parameter int NUM_SLICES = cla_seq_pkg::NUM_SLICES,
    parameter int SLICE_W    = cla_seq_pkg::SLICE_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          sub,
    input  logic [NUM_SLICES*SLICE_W-1:0] in1,
    input  logic [NUM_SLICES*SLICE_W-1:0] in2,
    input  logic                          c_in,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_SLICES*SLICE_W-1:0] sum,
    output logic                          c_out
);
    localparam int W  = NUM_SLICES * SLICE_W;
    localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    state_t state;
    logic [IW-1:0] idx;
    logic carry, s_cout;
    logic [W-1:0] a, b;
    logic [SLICE_W-1:0] s_sum;
    cla16 u_cla (
        .a    (a[idx*SLICE_W +: SLICE_W]),
        .b    (b[idx*SLICE_W +: SLICE_W]),
        .c_in (carry),
        .sum  (s_sum),
        .c_out(s_cout)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            a     <= '0;
            b     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a     <= in1;
                    b     <= sub ? ~in2 : in2;
                    carry <= sub | c_in;
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    sum[idx*SLICE_W +: SLICE_W] <= s_sum;
                    carry <= s_cout;
                    if (idx == IW'(NUM_SLICES - 1)) begin
                        idx   <= '0;
                        c_out <= s_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_64bit_sequencer.sv
// tb_cla_64bit_sequencer: directed vectors with a result scoreboard popped by a done-driven monitor.
module tb_cla_64bit_sequencer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, c_in = 1'b0;
    logic [63:0] in1 = '0, in2 = '0;
    logic busy, done, c_out;
    logic [63:0] sum;
    int cyc = 0, total = 0, fails = 0;

    typedef struct {
        logic [63:0] s;
        logic        c;
        int          acc;
        int          id;
    } exp_t;
    exp_t q[$];

    cla_64bit_sequencer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .sub  (sub),
        .in1  (in1),
        .in2  (in2),
        .c_in (c_in),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .c_out(c_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s op%0d: got %h expected %h", nm, id, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", -1, 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", e.id, sum, e.s);
                chk("c_out", e.id, {63'd0, c_out}, {63'd0, e.c});
                chk("latency", e.id, 64'(cyc - e.acc), 64'd4);
                chk("busy_at_done", e.id, {63'd0, busy}, 64'd0);
            end
        end
    end

    // Drives one operation, expecting acceptance at the next edge; returns on a negedge 6 cycles later.
    task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b, input logic ci,
                          input logic sb, input logic [63:0] es, input logic ec);
        exp_t e;
        in1 = a; in2 = b; c_in = ci; sub = sb; start = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_accept", id, {63'd0, busy}, 64'd1);
        e.s = es; e.c = ec; e.acc = cyc; e.id = id;
        q.push_back(e);
        start = 1'b0;
        in1 = ~in1; in2 = in2 ^ 64'hA5A5_A5A5_A5A5_A5A5; c_in = ~c_in; sub = ~sub;
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    logic [63:0] st_a[3] = '{64'h1234_5678_9ABC_DEF0, 64'h0, 64'h8000_0000_0000_0000};
    logic [63:0] st_b[3] = '{64'h0FED_CBA9_8765_4321, 64'h1, 64'h8000_0000_0000_0000};
    logic        st_c[3] = '{1'b0, 1'b0, 1'b1};
    logic        st_u[3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] st_s[3] = '{64'h2222_2222_2222_2211, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
    logic        st_o[3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum", 0, sum, 64'd0);
        chk("rst_c_out", 0, {63'd0, c_out}, 64'd0);
        chk("rst_busy", 0, {63'd0, busy}, 64'd0);
        chk("rst_done", 0, {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
        run_op(2, 64'd25001, 64'd40535, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
        run_op(3, 64'd25000, 64'd40535, 1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0);
        run_op(4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h0, 1'b1);
        run_op(5, 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op(6, 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1);
        // start held high; operands scrambled while each operation runs
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            in1 = st_a[i]; in2 = st_b[i]; c_in = st_c[i]; sub = st_u[i];
            @(posedge clk);
            #1;
            e.s = st_s[i]; e.c = st_o[i]; e.acc = cyc; e.id = 10 + i;
            q.push_back(e);
            @(negedge clk);
            in1 = 64'h5555_5555_5555_5555; in2 = 64'h3333_3333_3333_3333; c_in = ~c_in; sub = ~sub;
            repeat (5) @(posedge clk);
            if (i < 2) @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        // reset asserted mid-RUN, after two slices have been written
        in1 = 64'h0001_0001_0001_0001; in2 = 64'h0001_0001_0001_0001; c_in = 1'b0; sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("busy_mid_run", 20, {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 20, sum, 64'd0);
        chk("abort_c_out", 20, {63'd0, c_out}, 64'd0);
        chk("abort_busy", 20, {63'd0, busy}, 64'd0);
        chk("abort_done", 20, {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(21, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
               64'h0001_0000_0001_0000, 1'b0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 0, 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
